// File: rtl/addsub_serial_311.sv
// Digit-serial WIDTH-bit adder/subtractor: one DIGIT-bit slice per clock, LSB slice first.
// Optional macro ADDSUB_SERIAL_SAT_EN saturates the result on signed overflow.
module addsub_serial_311 #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk_311,
   input  logic             rst_n_311,
   input  logic             start_311,
   input  logic             mode_311,
   input  logic [WIDTH-1:0] a_311,
   input  logic [WIDTH-1:0] b_311,
   input  logic             cin_311,
   output logic             busy_311,
   output logic             done_311,
   output logic [WIDTH-1:0] s_311,
   output logic             c_311,
   output logic             v_311,
   output logic             z_311
);

   localparam int unsigned N       = WIDTH / DIGIT;
   localparam int unsigned CntW    = (N > 1) ? $clog2(N) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic [CntW-1:0]  r_cnt;
   logic             r_mode;
   logic             r_carry;
   logic             r_cmsb;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_s;
   logic             r_c;
   logic             r_v;
   logic             r_z;

   logic [DIGIT-1:0] w_a_sl;
   logic [DIGIT-1:0] w_b_sl;
   logic [DIGIT:0]   w_sum;
   logic             w_cmsb;
   logic             w_v;
   logic             w_c;
   logic [WIDTH-1:0] w_s;

   assign w_a_sl = r_a[r_cnt*DIGIT +: DIGIT];
   assign w_b_sl = r_b[r_cnt*DIGIT +: DIGIT];
   assign w_sum  = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{DIGIT{1'b0}}, r_carry};
   // Carry into the slice MSB; the value kept from the last slice is the carry into bit WIDTH-1.
   assign w_cmsb = w_a_sl[DIGIT-1] ^ w_b_sl[DIGIT-1] ^ w_sum[DIGIT-1];

   assign w_v = r_cmsb ^ r_carry;
   assign w_c = r_carry ^ r_mode;

`ifdef ADDSUB_SERIAL_SAT_EN
   // Wrapped sign 1 means positive overflow (clamp to max), sign 0 means negative (clamp to min).
   assign w_s = w_v ? {~r_acc[WIDTH-1], {(WIDTH-1){r_acc[WIDTH-1]}}} : r_acc;
`else
   assign w_s = r_acc;
`endif

   always_ff @(posedge clk_311) begin
      if (!rst_n_311) begin
         r_state <= StIdle;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_mode  <= 1'b0;
         r_carry <= 1'b0;
         r_cmsb  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_s     <= '0;
         r_c     <= 1'b0;
         r_v     <= 1'b0;
         r_z     <= 1'b1;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle, StDone: begin
               if (r_state == StDone) begin
                  r_s    <= w_s;
                  r_c    <= w_c;
                  r_v    <= w_v;
                  r_z    <= (w_s == '0);
                  r_done <= 1'b1;
               end
               if (start_311) begin
                  // Subtraction runs as a + ~b + ~cin.
                  r_a     <= a_311;
                  r_b     <= mode_311 ? ~b_311 : b_311;
                  r_mode  <= mode_311;
                  r_carry <= mode_311 ? ~cin_311 : cin_311;
                  r_cnt   <= '0;
                  r_acc   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= StRun;
               end else begin
                  r_state <= StIdle;
               end
            end
            StRun: begin
               r_acc[r_cnt*DIGIT +: DIGIT] <= w_sum[DIGIT-1:0];
               r_carry <= w_sum[DIGIT];
               r_cmsb  <= w_cmsb;
               if (r_cnt == LastCnt) begin
                  r_busy  <= 1'b0;
                  r_state <= StDone;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign busy_311 = r_busy;
   assign done_311 = r_done;
   assign s_311    = r_s;
   assign c_311    = r_c;
   assign v_311    = r_v;
   assign z_311    = r_z;

endmodule

// File: tb/tb_addsub_serial_311.sv
// Scoreboard bench for addsub_serial_311: stimulus pushes expected results, a monitor pops on done.
module tb_addsub_serial_311;

   parameter int DIGIT = 4;
   localparam int WIDTH = 16;
   localparam int N     = WIDTH / DIGIT;

`ifdef ADDSUB_SERIAL_SAT_EN
   localparam bit Sat = 1'b1;
`else
   localparam bit Sat = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        mode;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        busy;
   logic        done;
   logic [15:0] s;
   logic        c;
   logic        v;
   logic        z;

   typedef struct {
      logic [15:0] s;
      logic        c;
      logic        v;
      logic        z;
      int          t_start;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   addsub_serial_311 #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk_311   (clk),
      .rst_n_311 (rst_n),
      .start_311 (start),
      .mode_311  (mode),
      .a_311     (a),
      .b_311     (b),
      .cin_311   (cin),
      .busy_311  (busy),
      .done_311  (done),
      .s_311     (s),
      .c_311     (c),
      .v_311     (v),
      .z_311     (z)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (done === 1'b1) begin
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got done=1 want done=0 (s=%h)", s);
         end else begin
            e = q.pop_front();
            chk("s", {16'h0, s}, {16'h0, e.s});
            chk("c", {31'h0, c}, {31'h0, e.c});
            chk("v", {31'h0, v}, {31'h0, e.v});
            chk("z", {31'h0, z}, {31'h0, e.z});
            chk("latency", cyc - e.t_start, N + 1);
         end
      end
   end

   // Called at posedge+1; drives start for exactly one edge and queues the expectation.
   task automatic issue(input logic m, input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic, input logic [15:0] s_wrap, input logic [15:0] s_sat,
                        input logic ec, input logic ev);
      exp_t e;
      e.s       = Sat ? s_sat : s_wrap;
      e.c       = ec;
      e.v       = ev;
      e.z       = (e.s == 16'h0);
      e.t_start = cyc + 1;
      q.push_back(e);
      mode  = m;
      a     = ia;
      b     = ib;
      cin   = ic;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (q.size() != 0 && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL timeout: got %0d pending results want 0", q.size());
         q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nb;
      rst_n = 1'b0;
      start = 1'b0;
      mode  = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'h0, busy}, 0);
      chk("rst_done", {31'h0, done}, 0);
      chk("rst_s", {16'h0, s}, 0);
      chk("rst_c", {31'h0, c}, 0);
      chk("rst_v", {31'h0, v}, 0);
      chk("rst_z", {31'h0, z}, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Carry out of all-ones, plus busy duration
      issue(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
      nb = 0;
      for (int i = 0; i < N + 2; i++) begin
         @(negedge clk);
         if (busy) nb++;
      end
      chk("busy_cycles", nb, N);
      @(posedge clk);
      #1;
      wait_idle();

      issue(1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      wait_idle();
      issue(1'b1, 16'h1234, 16'h0234, 1'b1, 16'h0FFF, 16'h0FFF, 1'b0, 1'b0);
      wait_idle();
      issue(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1);
      wait_idle();
      issue(1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 16'h8000, 1'b0, 1'b1);
      wait_idle();
      issue(1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1);
      wait_idle();
      issue(1'b0, 16'h00FF, 16'h0F00, 1'b1, 16'h1000, 16'h1000, 1'b0, 1'b0);
      wait_idle();
      issue(1'b1, 16'h0001, 16'h0001, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      wait_idle();

      // Start during busy is ignored; then a start in the DONE cycle chains a second op
      issue(1'b0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 16'h0007, 1'b0, 1'b0);
      mode  = 1'b0;
      a     = 16'hAAAA;
      b     = 16'h5555;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (N - 1) begin
         @(posedge clk);
         #1;
      end
      issue(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 16'h5555, 1'b0, 1'b0);
      wait_idle();

      // Reset in the middle of RUN abandons the operation silently
      mode  = 1'b0;
      a     = 16'h1111;
      b     = 16'h2222;
      cin   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_busy", {31'h0, busy}, 0);
      chk("midrst_done", {31'h0, done}, 0);
      chk("midrst_s", {16'h0, s}, 0);
      chk("midrst_c", {31'h0, c}, 0);
      chk("midrst_v", {31'h0, v}, 0);
      chk("midrst_z", {31'h0, z}, 1);
      repeat (N + 3) @(posedge clk);
      #1;
      issue(1'b1, 16'h5555, 16'h1234, 1'b0, 16'h4321, 16'h4321, 1'b0, 1'b0);
      wait_idle();

      chk("pending_at_end", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/addsub_serial_311.md
Name: addsub_serial_311

Overview:
- Parametrised, digit-serial adder/subtractor; successor to the single-bit combinational half adder.
- Processes one DIGIT-bit slice per clock, LSB slice first, carrying between slices in a register.
- Start/busy/done handshake; carry/borrow, signed-overflow and zero flags.
- Used wherever a WIDTH-bit add/sub is needed at low area and multi-cycle latency is acceptable.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH. N = WIDTH/DIGIT slices.

Ports:
- clk_311  in  1  clock; all state changes on the rising edge.
- rst_n_311  in  1  synchronous, active-low reset.
- start_311  in  1  request; sampled only when not busy.
- mode_311  in  1  0 = add, 1 = subtract.
- a_311  in  WIDTH  operand A.
- b_311  in  WIDTH  operand B.
- cin_311  in  1  carry-in (add) or borrow-in (sub).
- busy_311  out  1  high while slices are being processed.
- done_311  out  1  one-cycle pulse; result valid.
- s_311  out  WIDTH  result.
- c_311  out  1  carry-out (add) or borrow-out (sub).
- v_311  out  1  two's-complement signed overflow.
- z_311  out  1  high when s_311 == 0.

Behaviour:
- Reset (rst_n_311 low at an edge) has priority over everything else:
  - state goes to IDLE;
  - busy_311, done_311, c_311, v_311 = 0; s_311 = 0; z_311 = 1;
  - an in-flight operation is abandoned; no done pulse is produced for it;
  - start_311 is ignored while reset is low.
- States:
  - IDLE: if start_311 is high at an edge, latch a, b, mode and cin; clear the slice counter and the internal accumulator; go to RUN.
  - RUN: each edge computes slice k = bits [k*DIGIT +: DIGIT], stores it into the accumulator and updates the carry register. After slice N-1, go to DONE.
  - DONE: one cycle, then IDLE. start_311 high in DONE is accepted exactly as in IDLE, so back-to-back operations are possible.
- Arithmetic:
  - Add: s = a + b + cin.
  - Subtract: s = a − b − cin, implemented as a + ~b + ~cin.
  - The internal carry register is initialised to cin (add) or ~cin (sub).
  - c_311 = final carry (add) or inverted final carry (sub), i.e. the true borrow.
  - v_311 = carry into MSB XOR carry out of MSB.
  - Results are modulo 2^WIDTH.
- Timing (start sampled at edge t):
  - busy_311 is high during cycles t+1 … t+N.
  - s_311, c_311, v_311 and z_311 update together at edge t+N+1; done_311 is high for the cycle following that edge.
  - Latency start → done is N+1 cycles.
  - Outputs hold their values until the next completed operation or reset. They never show partial results.
- start_311 while busy_311 is high is ignored; latched operands cannot change mid-operation.
- Operand inputs need only be stable at the start-sampling edge.
- DIGIT == WIDTH: a single RUN cycle (N = 1) with the same handshake.

Optional Feature:
- Macro: ADDSUB_SERIAL_SAT_EN.
- Defined: when v_311 would be 1, s_311 is saturated to 0x7F…F (positive overflow) or 0x80…0 (negative overflow). v_311 still reports the overflow. z_311 is evaluated on the saturated value.
- Undefined: wrap-around result only; no saturation logic is synthesised.

Test Plan (WIDTH=16, DIGIT=4 unless stated):
- Add 0xFFFF + 0x0001, cin=0 → s=0x0000, c=1, v=0, z=1; done 5 cycles after the start edge; busy high for exactly 4 cycles.
- Sub 0x0000 − 0x0001, cin=0 → s=0xFFFF, c=1 (borrow), v=0, z=0. Then sub 0x1234 − 0x0234, cin=1 → s=0x0FFF, c=0.
- Add 0x7FFF + 0x0001 → s=0x8000, v=1; with ADDSUB_SERIAL_SAT_EN → s=0x7FFF, v=1. Sub 0x8000 − 0x0001 → s=0x7FFF, v=1; saturated → 0x8000.
- Start 0x0003 + 0x0004, then pulse start with 0xAAAA + 0x5555 during busy → result 0x0007, only one done pulse. Then start again in the DONE cycle → second operation completes 5 cycles later.
- Reset low for one edge in the middle of RUN → all outputs at reset values, no done pulse, IDLE on the next cycle. A subsequent start gives a correct result.
- DIGIT=16 and DIGIT=1 builds: 0x1234 + 0x4321 → 0x5555, with done at 2 and 17 cycles respectively.
